// File: rtl/mem_resp.sv
// Memory responder with a single-entry read/write hit buffer and a fixed miss latency.
// Hits answer in the request cycle; misses and all writes finish LATENCY cycles later.
module mem_resp #(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic            v_r;
  logic [AW-1:0]   t_r;
  logic [15:0]     d_r;
  logic [15:0]     mem_r [0:(1<<AW)-1];

  logic [AW-1:0]   idx_s;
  logic            req_s;
  logic            rd_only_s;
  logic            hit_s;
  logic            finish_s;
  logic            commit_wr_s;
  logic            dump_unused_s;

  assign idx_s       = Addr[AW:1];
  assign req_s       = Rd | Wr;
  // Rd together with Wr is handled as a write, so it can never hit.
  assign rd_only_s   = Rd & ~Wr;
  assign hit_s       = rd_only_s & v_r & (t_r == idx_s);
  assign finish_s    = (state_r == BUSY) && (cnt_r == 4'd0);
  assign commit_wr_s = finish_s & Wr;
  assign dump_unused_s = createdump ^ (^Addr);

  // Response outputs and protocol error flag, decoded from state and the live request.
  always_comb begin
    Done     = 1'b0;
    Stall    = 1'b0;
    CacheHit = 1'b0;
    DataOut  = 16'h0000;
    err      = (Rd & Wr) | (Addr[0] & req_s) | ((state_r == BUSY) & ~req_s);
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          DataOut  = d_r;
        end else if (req_s) begin
          Stall = 1'b1;
        end else begin
          Stall = 1'b0;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_r == 4'd0) begin
          Done = 1'b1;
          if (rd_only_s) begin
            DataOut = mem_r[idx_s];
          end else begin
            DataOut = 16'h0000;
          end
        end else begin
          Done = 1'b0;
        end
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
  end

  // Control FSM, latency countdown and hit-buffer update on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      v_r     <= 1'b0;
      t_r     <= '0;
      d_r     <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !hit_s) begin
            state_r <= BUSY;
            cnt_r   <= LAT_M1;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
            // A withdrawn request leaves the buffer untouched.
            if (Wr) begin
              v_r <= 1'b1;
              t_r <= idx_s;
              d_r <= DataIn;
            end else if (Rd) begin
              v_r <= 1'b1;
              t_r <= idx_s;
              d_r <= mem_r[idx_s];
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_wr_s) begin
      mem_r[idx_s] <= DataIn;
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios pinned with literal values,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_resp;

  localparam int LATENCY = 4;
  localparam int AW      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic        createdump = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_resp #(.LATENCY(LATENCY), .AW(AW)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: memory contents, buffer contents, and the cycle a miss was accepted.
  logic [15:0] m_mem [int];
  bit          m_busy = 0;
  int          m_start = 0;
  bit          m_v = 0;
  int          m_t = 0;
  logic [15:0] m_d = 16'h0000;
  int          cyc = 0;

  always @(negedge clk) begin
    int idx;
    bit rq, rd, e_done, e_stall, e_hit, e_err, dchk;
    logic [15:0] e_dout;
    cyc++;
    if (rst) begin
      m_busy = 0; m_v = 0; m_t = 0; m_d = 16'h0000;
      chk("rst_done", {31'b0, Done}, 32'd0);
      chk("rst_stall", {31'b0, Stall}, 32'd0);
      chk("rst_hit", {31'b0, CacheHit}, 32'd0);
      chk("rst_dout", {16'b0, DataOut}, 32'd0);
    end else begin
      idx = int'(Addr[AW:1]);
      rq = Rd | Wr;
      rd = Rd & ~Wr;
      e_err = (Rd && Wr) || (Addr[0] && rq) || (m_busy && !rq);
      e_done = 0; e_stall = 0; e_hit = 0; e_dout = 16'h0000; dchk = 0;
      if (!m_busy) begin
        if (rd && m_v && m_t == idx) begin
          e_done = 1; e_hit = 1; e_dout = m_d; dchk = 1;
        end else if (rq) begin
          e_stall = 1; m_busy = 1; m_start = cyc;
        end else begin
          dchk = 1;
        end
      end else begin
        e_stall = 1;
        e_done = ((cyc - m_start) == LATENCY);
        if (e_done) begin
          m_busy = 0;
          if (Wr) begin
            m_mem[idx] = DataIn; m_v = 1; m_t = idx; m_d = DataIn;
          end else if (Rd) begin
            if (m_mem.exists(idx)) begin
              e_dout = m_mem[idx]; dchk = 1; m_v = 1; m_t = idx; m_d = m_mem[idx];
            end else begin
              m_v = 0;
            end
          end
        end
      end
      chk("done", {31'b0, Done}, {31'b0, e_done});
      chk("stall", {31'b0, Stall}, {31'b0, e_stall});
      chk("cachehit", {31'b0, CacheHit}, {31'b0, e_hit});
      chk("err", {31'b0, err}, {31'b0, e_err});
      if (dchk) chk("dataout", {16'b0, DataOut}, {16'b0, e_dout});
    end
  end

  // Drives one request (from posedge+1) and holds it until Done; returns what it saw.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] dat,
                        output int lat, output logic [15:0] dout, output logic hit,
                        output logic stall_and, output logic stall_or, output logic err0);
    Rd = rd; Wr = wr; Addr = a; DataIn = dat;
    lat = -1; dout = 16'h0000; hit = 1'b0; stall_and = 1'b1; stall_or = 1'b0; err0 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) err0 = err;
      stall_and &= Stall;
      stall_or  |= Stall;
      if (Done) begin
        lat = k; dout = DataOut; hit = CacheHit;
        break;
      end
      if (k == 20) chk("req_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'b0, Stall}, 32'd0);
    chk("idle_done", {31'b0, Done}, 32'd0);
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [15:0] dout;
  logic        hit, s_and, s_or, e0;
  int          pool [16];
  logic [15:0] a, last_a;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write miss: stalls cycles 0..4, Done in cycle 4.
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, dout, hit, s_and, s_or, e0);
    chk("wr_latency", lat, 32'd4);
    chk("wr_stall_all", {31'b0, s_and}, 32'd1);
    idle_cycle();

    // Read hit on the buffered write.
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, dout, hit, s_and, s_or, e0);
    chk("hit_latency", lat, 32'd0);
    chk("hit_flag", {31'b0, hit}, 32'd1);
    chk("hit_data", {16'b0, dout}, 32'h0000BEEF);
    chk("hit_nostall", {31'b0, s_or}, 32'd0);

    // Evicted word comes back from the array.
    do_req(1'b0, 1'b1, 16'h0020, 16'h1234, lat, dout, hit, s_and, s_or, e0);
    do_req(1'b0, 1'b1, 16'h0030, 16'h7777, lat, dout, hit, s_and, s_or, e0);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, lat, dout, hit, s_and, s_or, e0);
    chk("miss_latency", lat, 32'd4);
    chk("miss_data", {16'b0, dout}, 32'h00001234);
    chk("miss_hitflag", {31'b0, hit}, 32'd0);

    // Protocol errors: odd address, and Rd with Wr performing a write.
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000, lat, dout, hit, s_and, s_or, e0);
    chk("err_odd", {31'b0, e0}, 32'd1);
    do_req(1'b1, 1'b1, 16'h0050, 16'hA5A5, lat, dout, hit, s_and, s_or, e0);
    chk("err_rdwr", {31'b0, e0}, 32'd1);
    chk("rdwr_latency", lat, 32'd4);
    do_req(1'b0, 1'b1, 16'h0060, 16'h0001, lat, dout, hit, s_and, s_or, e0);
    do_req(1'b1, 1'b0, 16'h0050, 16'h0000, lat, dout, hit, s_and, s_or, e0);
    chk("rdwr_written", {16'b0, dout}, 32'h0000A5A5);

    // Reset in the middle of a write miss aborts it.
    do_req(1'b0, 1'b1, 16'h0040, 16'h0BAD, lat, dout, hit, s_and, s_or, e0);
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; Wr = 1'b0;
    #1;
    chk("abort_stall", {31'b0, Stall}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_req(1'b1, 1'b0, 16'h0040, 16'h0000, lat, dout, hit, s_and, s_or, e0);
    chk("abort_data", {16'b0, dout}, 32'h00000BAD);
    chk("abort_hitflag", {31'b0, hit}, 32'd0);

    // Back-to-back hits, one per cycle.
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, 16'h0040, 16'h0000, lat, dout, hit, s_and, s_or, e0);
      chk("b2b_latency", lat, 32'd0);
      chk("b2b_hit", {31'b0, hit}, 32'd1);
      chk("b2b_nostall", {31'b0, s_or}, 32'd0);
    end

    // Random traffic over a prewritten address pool.
    for (int i = 0; i < 16; i++) begin
      pool[i] = i * 13 + 2;
      do_req(1'b0, 1'b1, 16'(pool[i] << 1), 16'($urandom), lat, dout, hit, s_and, s_or, e0);
    end
    last_a = 16'(pool[0] << 1);
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(99));
      if ($urandom_range(99) < 35) a = last_a;
      else a = 16'(pool[$urandom_range(15)] << 1);
      last_a = a;
      if ($urandom_range(99) < 5) a = a | 16'h0001;
      if (op < 50)      do_req(1'b1, 1'b0, a, 16'($urandom), lat, dout, hit, s_and, s_or, e0);
      else if (op < 90) do_req(1'b0, 1'b1, a, 16'($urandom), lat, dout, hit, s_and, s_or, e0);
      else              do_req(1'b1, 1'b1, a, 16'($urandom), lat, dout, hit, s_and, s_or, e0);
      if ($urandom_range(99) < 15) idle_cycle();
    end

    Rd = 1'b0; Wr = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
